// File: rtl/mips_fmt_pkg.sv
// mips_fmt_pkg: shared MIPS instruction-format definitions.
//   - opcode constants for the R-type and jump formats
//   - bit positions of every instruction field
//   - FSM state encoding used by the program loader
//   - align_word(): clears the byte-offset bits of an address
package mips_fmt_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_JAL   = 6'd3;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer.
//   is_rtype          1 = R-format, 0 = I-format (J opcodes pack as I-format)
//   alu_sel  [5:0]    funct (R) or opcode (I)
//   rs, rt, rd, shamt register / shift fields (rd, shamt unused for I)
//   imm     [15:0]    immediate (unused for R)
//   word    [31:0]    packed instruction
//   reject            I-format with opcode 0 would decode as R-type
module instr_pack
  import mips_fmt_pkg::*;
(
  input  logic        is_rtype,
  input  logic [5:0]  alu_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        reject
);

  always_comb begin
    word   = '0;
    reject = 1'b0;
    if (is_rtype) begin
      word[OPC_HI:OPC_LO] = OPC_RTYPE;
      word[RS_HI:RS_LO]   = rs;
      word[RT_HI:RT_LO]   = rt;
      word[RD_HI:RD_LO]   = rd;
      word[SH_HI:SH_LO]   = shamt;
      word[FN_HI:FN_LO]   = alu_sel;
    end else begin
      word[OPC_HI:OPC_LO] = alu_sel;
      word[RS_HI:RS_LO]   = rs;
      word[RT_HI:RT_LO]   = rt;
      word[IMM_HI:IMM_LO] = imm;
      reject              = (alu_sel == OPC_RTYPE);
    end
  end

endmodule

// File: rtl/instr_composer.sv
// instr_composer: boot/test program loader in front of IMEM.
// Packs field bundles into MIPS words and writes them to consecutive word
// addresses starting at BASE_ADDR.
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a new load (ignored while loading)
//   in_valid / in_ready   bundle handshake
//   is_rtype .. last      bundle fields
//   imem_we/addr/wdata    registered IMEM write port
//   count                 words written since start
//   done                  high in DONE
//   err                   sticky: a bundle was rejected
//   dbg_state             current FSM state
//
// Handshake: a bundle transfers on any rising edge where in_valid and in_ready
// are both high. in_ready depends only on the FSM state. While in_valid is high
// and in_ready is low, the bundle fields must hold.
module instr_composer
  import mips_fmt_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_rtype,
  input  logic [5:0]      alu_sel,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [4:0]      shamt,
  input  logic [15:0]     imm,
  input  logic            last,
  output logic            imem_we,
  output logic [31:0]     imem_addr,
  output logic [31:0]     imem_wdata,
  output logic [ADDR_W:0] count,
  output logic            done,
  output logic            err,
  output state_t          dbg_state
);

  localparam logic [31:0]     BASE_AL   = align_word(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [31:0] word;
  logic        reject;
  logic        accept;
  logic        write_ok;
  logic        finish;
  logic [31:0] wr_addr;

  instr_pack u_pack (
    .is_rtype (is_rtype),
    .alu_sel  (alu_sel),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .imm      (imm),
    .word     (word),
    .reject   (reject)
  );

  assign in_ready  = (state == LOAD);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign accept   = in_valid & in_ready;
  assign write_ok = accept & ~reject;
  // Writing into the final slot ends the load even without last, so the
  // address never wraps back over the start of the program.
  assign finish   = accept & (last | (write_ok & (count == LAST_SLOT)));
  // count doubles as the word index of the next write.
  assign wr_addr  = BASE_AL + (32'(count) << 2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = LOAD;
      LOAD:    if (finish) state_nxt = DONE;
      DONE:    if (start)  state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_AL;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      state   <= state_nxt;
      imem_we <= write_ok;
      if (write_ok) begin
        imem_addr  <= wr_addr;
        imem_wdata <= word;
        count      <= count + ONE;
      end
      if (accept & reject) err <= 1'b1;
      // accept is only possible in LOAD, so this never collides with a write.
      if ((state != LOAD) && start) begin
        count <= '0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_composer.sv
module tb_instr_composer;
  import mips_fmt_pkg::*;

  localparam int          ADDR_W = 2;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int          W      = ADDR_W + 1 + 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0, in_valid = 1'b0, is_rtype = 1'b0, last = 1'b0;
  logic [5:0]      alu_sel = '0;
  logic [4:0]      rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0]     imm = '0;
  logic            in_ready, imem_we, done, err;
  logic [31:0]     imem_addr, imem_wdata;
  logic [ADDR_W:0] count;
  state_t          dbg_state;

  instr_composer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_rtype   (is_rtype),
    .alu_sel    (alu_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .imm        (imm),
    .last       (last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];   // {count after write, byte address, word}

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_loading = 1'b0;
  bit m_done    = 1'b0;
  bit m_err     = 1'b0;
  bit m_chk_rst = 1'b1;
  int m_count   = 0;

  function automatic logic [31:0] ref_word(input bit r, input logic [5:0] sel,
                                           input logic [4:0] a, input logic [4:0] b,
                                           input logic [4:0] c, input logic [4:0] sh,
                                           input logic [15:0] im);
    if (r) return (32'(a) << 21) | (32'(b) << 16) | (32'(c) << 11) | (32'(sh) << 6) | 32'(sel);
    return (32'(sel) << 26) | (32'(a) << 21) | (32'(b) << 16) | 32'(im);
  endfunction

  task automatic check_outputs();
    logic [ADDR_W:0] mc;
    state_t es;
    mc = m_count[ADDR_W:0];
    es = m_loading ? LOAD : (m_done ? DONE : IDLE);
    check("in_ready", W'(in_ready), W'(m_loading));
    check("done",     W'(done),     W'(m_done));
    check("err",      W'(err),      W'(m_err));
    check("count",    W'(count),    W'(mc));
    check("state",    W'(dbg_state), W'(es));
    if (m_chk_rst) begin
      check("reset_we",    W'(imem_we),    W'(1'b0));
      check("reset_addr",  W'(imem_addr),  W'(BASE));
      check("reset_wdata", W'(imem_wdata), W'(32'h0));
      m_chk_rst = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check state left by the previous edge, drive inputs,
  // then advance the model to what the coming edge must produce.
  task automatic cycle(input bit rst, input bit st, input bit v, input bit rtp,
                       input logic [5:0] sel, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic [4:0] sh, input logic [15:0] im,
                       input bit lst, output bit acc);
    logic [ADDR_W:0] ec;
    logic [31:0]     ea;
    @(negedge clk);
    check_outputs();
    reset = rst; start = st; in_valid = v; is_rtype = rtp; alu_sel = sel;
    rs = a; rt = b; rd = c; shamt = sh; imm = im; last = lst;
    acc = 1'b0;
    if (rst) begin
      m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = 0; m_chk_rst = 1'b1;
    end else if (m_loading) begin
      if (v) begin
        acc = 1'b1;
        if (!rtp && sel == 6'd0) begin
          m_err = 1'b1;
          if (lst) begin m_loading = 1'b0; m_done = 1'b1; end
        end else begin
          ec = (ADDR_W + 1)'(m_count + 1);
          ea = BASE + 32'(m_count * 4);
          exp_q.push_back({ec, ea, ref_word(rtp, sel, a, b, c, sh, im)});
          m_count++;
          if (lst || m_count == DEPTH) begin m_loading = 1'b0; m_done = 1'b1; end
        end
      end
    end else if (st) begin
      m_loading = 1'b1; m_done = 1'b0; m_err = 1'b0; m_count = 0;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("write", {count, imem_addr, imem_wdata}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc, pv, pa, v, st, r, l;
    logic [5:0]  s;
    logic [4:0]  a, b, c, sh;
    logic [15:0] im;

    repeat (2) @(posedge clk);

    // single R word with last
    cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    cycle(0, 0, 1, 1, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1, acc);
    idle(3);

    // I word then R word back to back
    cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    cycle(0, 0, 1, 0, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 0, acc);
    cycle(0, 0, 1, 1, 6'h22, 5'd4, 5'd5, 5'd6, 5'd7, 16'd0, 1, acc);
    idle(2);

    // rejected I word mid-stream
    cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    cycle(0, 0, 1, 0, 6'h23, 5'd9, 5'd10, 5'd0, 5'd0, 16'h0040, 0, acc);
    cycle(0, 0, 1, 0, 6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1234, 0, acc);
    cycle(0, 0, 1, 1, 6'h2A, 5'd11, 5'd12, 5'd13, 5'd2, 16'd0, 1, acc);
    idle(2);

    // overflow: six bundles without last into a four-word memory
    cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 1, 1, 6'(i + 1), 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'd0, 0, acc);
    idle(2);

    // reset the cycle after an accept, then reset during an accept cycle
    cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    cycle(0, 0, 1, 0, 6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 0, acc);
    cycle(1, 0, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    idle(2);
    cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
    cycle(1, 0, 1, 1, 6'h21, 5'd1, 5'd1, 5'd1, 5'd1, 16'd0, 0, acc);
    idle(2);

    // random programs: valid gaps, stray start pulses, rejects, rare resets
    pv = 1'b0; pa = 1'b0;
    s = '0; a = '0; b = '0; c = '0; sh = '0; im = '0; r = 1'b0; l = 1'b0;
    for (int p = 0; p < 40; p++) begin
      cycle(0, 1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0, acc);
      pv = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (!(pv && !pa)) begin
          r  = 1'($urandom_range(0, 1));
          s  = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
          a  = 5'($urandom_range(0, 31));
          b  = 5'($urandom_range(0, 31));
          c  = 5'($urandom_range(0, 31));
          sh = 5'($urandom_range(0, 31));
          im = 16'($urandom_range(0, 65535));
          l  = ($urandom_range(0, 5) == 0);
          v  = ($urandom_range(0, 3) != 0);
        end else begin
          v = 1'b1;
        end
        st = ($urandom_range(0, 6) == 0);
        cycle(($urandom_range(0, 60) == 0), st, v, r, s, a, b, c, sh, im, l, acc);
        pv = v; pa = acc;
      end
      idle(1);
    end

    idle(3);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lost_writes: got %0d words still pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
